// File: rtl/note_hit_judge.sv
// Judges lane presses against the 24 falling-square slots and sweeps late squares as misses.
// Press-to-judgement latency is 8 cycles after the latched press; a miss sweep takes 25 cycles; requests queue in pending bits.
module note_hit_judge #(
  parameter int SLOTS   = 6,
  parameter int POS_W   = 10,
  parameter int HIT_Y   = 400,
  parameter int WINDOW  = 16,
  parameter int PERFECT = 4,
  parameter int SCORE_W = 16
) (
  input  logic                     clk,
  input  logic                     RST_BTN,
  input  logic [3:0]               btn,
  input  logic                     frame_tick,
  input  logic [4*SLOTS-1:0]       slot_active,
  input  logic [4*SLOTS*POS_W-1:0] slot_y,
  output logic [4*SLOTS-1:0]       clear,
  output logic                     judge_valid,
  output logic [1:0]               judge_lane,
  output logic [1:0]               judge_result,
  output logic [SCORE_W-1:0]       score,
  output logic [7:0]               combo,
  output logic                     busy
);

  localparam int NSLOT = 4 * SLOTS;
  localparam int IW    = $clog2(NSLOT);
  localparam int SW    = $clog2(SLOTS);
  localparam int DW    = POS_W + 1;
  localparam logic [DW-1:0] HIT  = DW'(HIT_Y);
  localparam logic [DW-1:0] LO   = DW'(HIT_Y - WINDOW);
  localparam logic [DW-1:0] HI   = DW'(HIT_Y + WINDOW);
  localparam logic [DW-1:0] PERF = DW'(PERFECT);

  typedef enum logic [1:0] {IDLE, LSCAN, RESOLVE, MSCAN} state_t;

  state_t              state_q, state_d;
  logic [3:0]          pending_q, pending_d;
  logic                miss_q, miss_d;
  logic [1:0]          lane_q, lane_d;
  logic [SW-1:0]       s_q, s_d, best_q, best_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                found_q, found_d;
  logic [DW-1:0]       best_dist_q, best_dist_d;
  logic [NSLOT-1:0]    clear_q, clear_d;
  logic                jv_q, jv_d;
  logic [1:0]          jl_q, jl_d, jr_q, jr_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [7:0]          combo_q, combo_d;

  logic [POS_W-1:0]    y_arr [NSLOT];
  logic [IW-1:0]       lane_base, scan_idx;
  logic [DW-1:0]       cur_y, cur_dist;
  logic                cur_act, in_win, late, perfect;
  logic [SCORE_W:0]    sum;
  logic [3:0]          pend_clr;
  logic                miss_clr;
  logic [1:0]          lsel;

  for (genvar i = 0; i < NSLOT; i++) begin : g_y
    assign y_arr[i] = slot_y[POS_W*i +: POS_W];
  end

  // Distance is taken one bit wider than y so the subtraction never wraps.
  always_comb begin
    lane_base = IW'(lane_q) * IW'(SLOTS);
    scan_idx  = (state_q == MSCAN) ? idx_q : lane_base + IW'(s_q);
    cur_y     = {1'b0, y_arr[scan_idx]};
    cur_act   = slot_active[scan_idx];
    cur_dist  = (cur_y >= HIT) ? cur_y - HIT : HIT - cur_y;
    in_win    = cur_act && (cur_y >= LO) && (cur_y <= HI);
    late      = cur_act && (cur_y > HI);
    perfect   = best_dist_q <= PERF;
    sum       = {1'b0, score_q} + (SCORE_W+1)'(perfect ? 3 : 1);
    lsel      = 2'd0;
    for (int l = 3; l >= 0; l--) begin
      if (pending_q[l]) lsel = 2'(l);
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    s_d         = s_q;
    best_d      = best_q;
    idx_d       = idx_q;
    found_d     = found_q;
    best_dist_d = best_dist_q;
    clear_d     = '0;
    jv_d        = 1'b0;
    jl_d        = jl_q;
    jr_d        = jr_q;
    score_d     = score_q;
    combo_d     = combo_q;
    pend_clr    = 4'b0;
    miss_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_q) begin
          miss_clr = 1'b1;
          idx_d    = '0;
          state_d  = MSCAN;
        end else if (|pending_q) begin
          pend_clr[lsel] = 1'b1;
          lane_d   = lsel;
          s_d      = '0;
          found_d  = 1'b0;
          state_d  = LSCAN;
        end
      end
      LSCAN: begin
        // Strict less-than keeps the lower slot on a distance tie.
        if (in_win && (!found_q || cur_dist < best_dist_q)) begin
          found_d     = 1'b1;
          best_d      = s_q;
          best_dist_d = cur_dist;
        end
        if (s_q == SW'(SLOTS - 1)) state_d = RESOLVE;
        else                       s_d     = s_q + 1'b1;
      end
      RESOLVE: begin
        jv_d    = 1'b1;
        jl_d    = lane_q;
        state_d = IDLE;
        if (found_q) begin
          clear_d[lane_base + IW'(best_q)] = 1'b1;
          jr_d    = perfect ? 2'b10 : 2'b01;
          score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
        end else begin
          jr_d    = 2'b00;
          combo_d = 8'd0;
        end
      end
      MSCAN: begin
        if (late) begin
          clear_d[idx_q] = 1'b1;
          jv_d    = 1'b1;
          jl_d    = 2'(idx_q / IW'(SLOTS));
          jr_d    = 2'b00;
          combo_d = 8'd0;
        end
        if (idx_q == IW'(NSLOT - 1)) state_d = IDLE;
        else                         idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A new request in the dispatch cycle survives the clear.
    pending_d = (pending_q & ~pend_clr) | btn;
    miss_d    = (miss_q & ~miss_clr) | frame_tick;
  end

  always_ff @(posedge clk) begin
    if (RST_BTN) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      miss_q      <= 1'b0;
      lane_q      <= '0;
      s_q         <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      best_dist_q <= '0;
      clear_q     <= '0;
      jv_q        <= 1'b0;
      jl_q        <= '0;
      jr_q        <= '0;
      score_q     <= '0;
      combo_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      miss_q      <= miss_d;
      lane_q      <= lane_d;
      s_q         <= s_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      best_dist_q <= best_dist_d;
      clear_q     <= clear_d;
      jv_q        <= jv_d;
      jl_q        <= jl_d;
      jr_q        <= jr_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
    end
  end

  assign clear        = clear_q;
  assign judge_valid  = jv_q;
  assign judge_lane   = jl_q;
  assign judge_result = jr_q;
  assign score        = score_q;
  assign combo        = combo_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/note_hit_judge.md
Name: note_hit_judge

Overview:
- Retire side of the falling-square playfield: consumes the 24 square slots (4 lanes × 6 slots) that the spawner fills, and judges player presses against them.
- On a lane press, scans that lane for the active square nearest the hit line, then retires it and scores it.
- Once per frame, sweeps all slots and retires squares that have fallen past the hit window as misses.
- Drives per-slot clear pulses back to the spawner, plus score and combo to the display logic.

Parameters:
- SLOTS, 6, slots per lane; slot index = lane*SLOTS + s
- POS_W, 10, width of one square y coordinate
- HIT_Y, 400, y of the hit line
- WINDOW, 16, half-width of the hit window
- PERFECT, 4, half-width of the perfect zone (must be ≤ WINDOW)
- SCORE_W, 16, width of the score counter

Ports:
- clk  in  1  system clock
- RST_BTN  in  1  synchronous active-high reset
- btn  in  4  per-lane press pulses, one cycle each, already debounced
- frame_tick  in  1  one-cycle pulse once per video frame
- slot_active  in  24  slot i holds a live square
- slot_y  in  24*POS_W  y of slot i at bits [POS_W*i+POS_W-1 : POS_W*i]
- clear  out  24  one-cycle pulse that retires slot i
- judge_valid  out  1  one-cycle pulse: a judgement is present on judge_lane/judge_result
- judge_lane  out  2  lane of the current judgement
- judge_result  out  2  judgement code: 00 miss, 01 good, 10 perfect
- score  out  SCORE_W  accumulated score
- combo  out  8  consecutive non-miss count
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (synchronous, RST_BTN high at a clk edge):
  - state goes to IDLE; pending[3:0] and miss_pending are cleared.
  - clear, judge_valid, judge_lane, judge_result, score and combo all go to 0.
  - Reset overrides everything. Reset during a scan aborts it with no clear pulse and no judge_valid.
- Request latching:
  - btn[L] sets pending[L]; frame_tick sets miss_pending.
  - Pending bits clear when IDLE dispatches the request.
  - A set and a dispatch-clear in the same cycle: the set wins.
  - A press during the scan of its own lane is therefore served again afterwards.
  - Repeat presses while a bit is already set merge into one request.
- States: IDLE, LSCAN, RESOLVE, MSCAN.
- IDLE:
  - miss_pending has priority → MSCAN with idx=0.
  - Otherwise the lowest L with pending[L] → LSCAN with lane=L, s=0, found=0.
  - Otherwise stay in IDLE.
- LSCAN (one slot per cycle, s = 0..5):
  - Candidate test: slot active and HIT_Y-WINDOW ≤ y ≤ HIT_Y+WINDOW.
  - dist = |y - HIT_Y|, computed at POS_W+1 bits so the subtraction cannot wrap.
  - Keep the candidate with the smallest dist; a tie keeps the lower s.
  - After s=5 → RESOLVE.
  - slot_y and slot_active are sampled live each cycle; there is no snapshot.
- RESOLVE (one cycle, registered outputs):
  - Candidate found:
    - clear[best]=1, judge_valid=1, judge_lane=lane.
    - judge_result=10 if dist ≤ PERFECT, else 01.
    - score += 3 (perfect) or 1 (good), saturating at 2^SCORE_W-1.
    - combo += 1, saturating at 255.
  - No candidate: judge_valid=1, judge_result=00, combo←0, no clear pulse.
  - Next state is IDLE.
- MSCAN (idx = 0..23, one slot per cycle):
  - Active slot with y > HIT_Y+WINDOW: next cycle clear[idx]=1, judge_valid=1, judge_lane=idx/SLOTS, judge_result=00, combo←0.
  - Several misses produce back-to-back single-cycle pulses.
  - After idx=23 → IDLE.
- Latency: a btn pulse sampled at edge N with the block idle gives judge_valid during the cycle after edge N+8. A full miss sweep takes 25 cycles.
- clear is one-hot or zero every cycle.
- The spawner must drop slot_active[i] within one cycle of clear[i]. Until it does, that square can still be picked by the next scan.

Test Plan:
- Single press, exact hit: slot 6 (lane 1, s=0) active at y=400, btn=0010 → 8 cycles later clear[6]=1, judge_lane=1, judge_result=10; score 0→3, combo 0→1.
- Good and nearest pick: lane 0, slots 0/1/2 at y=390/410/430, all active, btn=0001 → clear[0] (dist 10, tie with slot 1 goes to the lower s), result 01, score +1. Slot 2 (dist 30) is not chosen.
- Empty press: lane 3 with no active slot in the window, combo=5, btn=1000 → judge_valid with result 00, no clear pulse, combo=0, score unchanged.
- Frame miss sweep: slots 3 and 20 active at y=417 and y=500, slot 8 at y=416, frame_tick → clear[3] pulse then clear[20] pulse (lanes 0 and 3, result 00), combo=0; slot 8 is not cleared; busy low 25 cycles after dispatch.
- Simultaneous requests: frame_tick and btn=0101 in the same cycle → miss sweep first, then lane 0, then lane 2. A btn[0] pulse during the lane-0 LSCAN yields a second lane-0 judgement.
- Reset and saturation:
  - RST_BTN asserted mid-LSCAN → no clear pulse; all outputs 0 next cycle.
  - Preload score=65534, then a perfect hit → score=65535.
